// File: rtl/cnt_seq_pkg.sv
// Shared encodings for the counter sequencing controller.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/cnt_core.sv
// N-bit synchronous up/down counter with parallel load and count enable.
module cnt_core
  import cnt_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] q
);

  // Load wins over counting; the count is modulo 2^N.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (dir == DOWN) ? q - N'(1) : q + N'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Start/stop/pause sequencer around cnt_core: run control, terminal detect,
// done pulse and saturating completed-period tally.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          mode_down,
  input  logic          reload,
  input  logic [N-1:0]  limit,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          paused,
  output logic          done,
  output logic [PW-1:0] periods
);

  state_e       state, state_nxt;
  logic [N-1:0] lim_r;
  logic         down_r;
  logic         reload_r;

  logic [N-1:0] term;
  logic [N-1:0] step_q;
  logic         at_term;
  logic         hit;

  logic         load;
  logic [N-1:0] load_val;
  logic         en;
  logic         done_set;
  logic         per_clr;
  logic         per_one;
  logic         per_inc;
  logic         cfg_latch;

  // Terminal compare against the value the next step would produce.
  assign term    = (down_r == DOWN) ? '0 : lim_r;
  assign step_q  = (down_r == DOWN) ? q - N'(1) : q + N'(1);
  assign at_term = (q == term);
  assign hit     = !at_term && (step_q == term);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (limit != '0)) state_nxt = RUN;
      RUN: begin
        if (stop)                  state_nxt = IDLE;
        else if (pause)            state_nxt = PAUSE;
        else if (hit && !reload_r) state_nxt = IDLE;
      end
      PAUSE: begin
        if (stop)        state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == PAUSE);
    paused    = (state == PAUSE);
    load      = 1'b0;
    load_val  = '0;
    en        = 1'b0;
    done_set  = 1'b0;
    per_clr   = 1'b0;
    per_one   = 1'b0;
    per_inc   = 1'b0;
    cfg_latch = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cfg_latch = 1'b1;
          load      = 1'b1;
          load_val  = (mode_down == DOWN) ? limit : '0;
          // A zero limit completes immediately without leaving IDLE.
          if (limit == '0) begin
            done_set = 1'b1;
            per_one  = 1'b1;
          end else begin
            per_clr  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stop && !pause) begin
          if (at_term) begin
            load     = 1'b1;
            load_val = (down_r == DOWN) ? lim_r : '0;
          end else begin
            en = 1'b1;
            if (hit) begin
              done_set = 1'b1;
              per_inc  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lim_r    <= '0;
      down_r   <= UP;
      reload_r <= 1'b0;
      done     <= 1'b0;
      periods  <= '0;
    end else begin
      if (cfg_latch) begin
        lim_r    <= limit;
        down_r   <= mode_down;
        reload_r <= reload;
      end
      done <= done_set;
      if (per_clr) begin
        periods <= '0;
      end else if (per_one) begin
        periods <= PW'(1);
      end else if (per_inc && (periods != '1)) begin
        periods <= periods + PW'(1);
      end
    end
  end

  cnt_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (down_r),
    .q        (q)
  );

endmodule
